irq_redirect_ctrl: RTL

- Machine-mode interrupt and return controller for the riscv32i core.
- Drives the PC generator's redirect inputs: `irq_prep`, `interrupt_vector`, `mepc` and `mret_inst`. Consumes the PC generator's current PC, its jump/branch redirect flag and the IF-ready status.
- Owns the CSRs `mstatus` (MIE/MPIE only), `mtvec`, `mepc` and `mcause`. Sequences one interrupt entry per handler and the matching `mret` exit.

---
 rtl/irq_redirect_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/irq_redirect_ctrl.sv
// irq_redirect_ctrl
//   Machine-mode interrupt entry / mret exit sequencer for the riscv32i core.
//   It owns mstatus (MIE/MPIE only), mtvec, mepc and mcause. It drives the
//   PC generator's redirect requests: irq_prep_o on interrupt entry and
//   mret_inst_o on return.
//
// Ports
//   clk_i, reset_i        core clock, synchronous active-high reset
//   enable_design         global enable; low freezes all state and CSRs
//   irq_i                 level-sensitive external interrupt request
//   pc_i                  current PC from the PC generator
//   change_pc_i           jump/branch redirect in progress this cycle
//   stage_IF_ready_i      IF accepts a new PC this cycle
//   mret_i                decoded mret (1-cycle pulse)
//   csr_we_i/addr/wdata   CSR write port
//   csr_rdata_o           CSR read data, combinational on csr_addr_i
//   irq_prep_o            interrupt redirect request (1-cycle pulse)
//   interrupt_vector_o    handler address (= mtvec)
//   mepc_o                return address (= mepc)
//   mret_inst_o           return redirect request (1-cycle pulse)
//   in_handler_o          high while inside the handler
module irq_redirect_ctrl #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  MTVEC_RESET = 32'h0000_0100,
  parameter logic             MIE_RESET   = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            enable_design,
  input  logic            irq_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            change_pc_i,
  input  logic            stage_IF_ready_i,
  input  logic            mret_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            irq_prep_o,
  output logic [XLEN-1:0] interrupt_vector_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mret_inst_o,
  output logic            in_handler_o
);

  localparam logic [11:0]     A_MSTATUS = 12'h300;
  localparam logic [11:0]     A_MTVEC   = 12'h305;
  localparam logic [11:0]     A_MEPC    = 12'h341;
  localparam logic [11:0]     A_MCAUSE  = 12'h342;
  // Machine external interrupt: interrupt bit set, exception code 11.
  localparam logic [XLEN-1:0] MCAUSE_MEI = {1'b1, (XLEN-1)'(11)};
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HANDLER} state_t;

  state_t          r_state, w_next;
  logic            r_mie, r_mpie;
  logic [XLEN-1:0] r_mtvec, r_mepc, r_mcause;

  logic            w_pending, w_boundary, w_take, w_ret, w_sw_wr;
  logic [XLEN-1:0] w_mepc_cap, w_mstatus;

  assign w_pending  = irq_i & r_mie;
  // An instruction boundary: IF can accept, no branch/jump redirect is in
  // flight (branches always win), and no mret is being retired.
  assign w_boundary = stage_IF_ready_i & ~change_pc_i & ~mret_i;
  assign w_take     = enable_design & (r_state == S_WAIT) & w_pending & w_boundary;
  assign w_ret      = enable_design & (r_state == S_HANDLER) & mret_i;
  assign w_sw_wr    = csr_we_i & enable_design;
  assign w_mepc_cap = (pc_i + XLEN'(4)) & ALIGN_MASK;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i)            r_state <= S_IDLE;
    else if (enable_design) r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pending) w_next = S_WAIT;
      // The request is level-sensitive, so a drop while waiting cancels it.
      S_WAIT:    if (!w_pending) w_next = S_IDLE;
                 else if (w_boundary) w_next = S_HANDLER;
      S_HANDLER: if (mret_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    irq_prep_o   = w_take;
    mret_inst_o  = w_ret;
    in_handler_o = (r_state == S_HANDLER);
  end

  // ---------------- CSRs ----------------
  // Software writes are applied first and hardware captures after them, so
  // when both land in one cycle the hardware value wins for the fields it
  // touches (last non-blocking assignment takes effect).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mie    <= MIE_RESET;
      r_mpie   <= 1'b0;
      r_mtvec  <= MTVEC_RESET;
      r_mepc   <= '0;
      r_mcause <= '0;
    end else if (enable_design) begin
      if (w_sw_wr) begin
        case (csr_addr_i)
          A_MSTATUS: begin
            r_mie  <= csr_wdata_i[3];
            r_mpie <= csr_wdata_i[7];
          end
          A_MTVEC:   r_mtvec <= csr_wdata_i & ALIGN_MASK;
          A_MEPC:    r_mepc  <= csr_wdata_i & ALIGN_MASK;
          default:   ;
        endcase
      end
      if (w_take) begin
        r_mepc   <= w_mepc_cap;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
        r_mcause <= MCAUSE_MEI;
      end
      if (w_ret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    w_mstatus    = '0;
    w_mstatus[3] = r_mie;
    w_mstatus[7] = r_mpie;
  end

  always_comb begin
    case (csr_addr_i)
      A_MSTATUS: csr_rdata_o = w_mstatus;
      A_MTVEC:   csr_rdata_o = r_mtvec;
      A_MEPC:    csr_rdata_o = r_mepc;
      A_MCAUSE:  csr_rdata_o = r_mcause;
      default:   csr_rdata_o = '0;
    endcase
  end

  assign interrupt_vector_o = r_mtvec;
  assign mepc_o             = r_mepc;

endmodule
